// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// Optional signed-overflow output is enabled with SERIAL_SUB_OVF_EN.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } sub_state_t;

  localparam int unsigned SERIAL_SUB_DEFAULT_N = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, bout = borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit unsigned subtractor (A - B, LSB first) with valid/ready handshakes.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned N = SERIAL_SUB_DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  sub_state_t    state;
  logic [N-1:0]  a_sr;
  logic [N-1:0]  b_sr;
  logic [N-1:0]  diff_sr;
  logic [CW-1:0] bcnt;
  logic          borrow_r;
  logic          in_ready_r;
  logic          out_valid_r;
  logic          x;
  logic          y;
  logic          d;
  logic          bout;

  assign x = a_sr[0];
  assign y = b_sr[0];

  full_subtractor u_fs (
    .x    (x),
    .y    (y),
    .bin  (borrow_r),
    .d    (d),
    .bout (bout)
  );

  // Handshake outputs are registered alongside the state so they never
  // depend combinationally on in_valid or out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_sr        <= '0;
      b_sr        <= '0;
      diff_sr     <= '0;
      bcnt        <= '0;
      borrow_r    <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            a_sr       <= a;
            b_sr       <= b;
            bcnt       <= '0;
            borrow_r   <= 1'b0;
            in_ready_r <= 1'b0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr     <= {1'b0, a_sr[N-1:1]};
          b_sr     <= {1'b0, b_sr[N-1:1]};
          diff_sr  <= {d, diff_sr[N-1:1]};
          borrow_r <= bout;
          bcnt     <= bcnt + CW'(1);
          if (bcnt == LAST) begin
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_r;

  // Sign bits are the operand MSBs, seen on the last SHIFT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (state == SHIFT && bcnt == LAST) begin
      ovf_r <= (x ^ y) & (x ^ d);
    end
  end

  assign ovf = ovf_r;
`endif

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign diff      = diff_sr;
  assign borrow    = borrow_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor; ovf checks compile in with SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic [N-1:0] diff;
  logic         in_ready;
  logic         out_valid;
  logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  typedef struct {
    logic [N-1:0] d;
    logic         br;
    logic         ov;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_edge = -100;
  int   hs_edge = -100;
  int   n_acc = 0;
  logic prev_ov = 1'b0;

  serial_subtractor #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares the presented result with the queue head each cycle it is valid.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        acc_edge = cyc + 1;
        n_acc = n_acc + 1;
      end
      if (out_valid && !prev_ov) chk("latency", cyc - acc_edge, N);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          chk("diff", diff, exp_q[0].d);
          chk("borrow", borrow, exp_q[0].br);
`ifdef SERIAL_SUB_OVF_EN
          chk("ovf", ovf, exp_q[0].ov);
`endif
          if (out_ready) begin
            void'(exp_q.pop_front());
            hs_edge = cyc + 1;
          end
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic push_exp(input logic [N-1:0] d, input logic br, input logic ov);
    exp_t e;
    e.d = d;
    e.br = br;
    e.ov = ov;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [N-1:0] av, input logic [N-1:0] bv,
                       input logic [N-1:0] d, input logic br, input logic ov);
    int t;
    push_exp(d, br, ov);
    a = av;
    b = bv;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("accept_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic finish_op();
    int t;
    t = 0;
    while (!(out_valid && out_ready) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("result_handshake_seen", out_valid && out_ready, 1);
    @(posedge clk); #1;
    chk("in_ready_after_hs", in_ready, 1);
    chk("out_valid_after_hs", out_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int base;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    out_ready = 1'b1;
    issue(8'd100, 8'd37, 8'd63, 1'b0, 1'b0);
    finish_op();
    issue(8'd5, 8'd10, 8'hFB, 1'b1, 1'b0);
    finish_op();
    issue(8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    finish_op();
    issue(8'd255, 8'd255, 8'd0, 1'b0, 1'b0);
    finish_op();

    // Stall the consumer; in_valid pulses during SHIFT/DONE must be ignored
    out_ready = 1'b0;
    issue(8'hC3, 8'h3C, 8'h87, 1'b0, 1'b0);
    a = 8'hFF;
    b = 8'h01;
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_shift", in_ready, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("hold_out_valid", out_valid, 1);
    a = 8'h11;
    b = 8'h22;
    in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("hold_still_valid", out_valid, 1);
    chk("in_ready_done", in_ready, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    finish_op();

    // Back-to-back with in_valid held high
    push_exp(8'd7, 1'b0, 1'b0);
    push_exp(8'd249, 1'b1, 1'b0);
    base = n_acc;
    a = 8'd10;
    b = 8'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    a = 8'd3;
    b = 8'd10;
    t = 0;
    while (n_acc < base + 2 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0;
    chk("b2b_accepts", n_acc - base, 2);
    chk("b2b_gap", acc_edge - hs_edge, 1);
    finish_op();

    // Reset in the middle of SHIFT abandons the operation
    push_exp(8'hFF, 1'b1, 1'b0);
    a = 8'h00;
    b = 8'h01;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_diff", diff, 0);
    chk("midrst_borrow", borrow, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(8'd9, 8'd9, 8'd0, 1'b0, 1'b0);
    finish_op();

`ifdef SERIAL_SUB_OVF_EN
    issue(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    finish_op();
    issue(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);
    finish_op();
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
